// File: rtl/traffic_control_n.sv
// traffic_control_n: N-way round-robin traffic signal controller.
//
// Each approach is given GREEN and then YELLOW in turn, with an ALL_RED
// clearance phase between any two greens. With SKIP_EMPTY set, approaches
// whose sense bit is low are passed over. An emergency request forces green
// onto a chosen approach; the current green is first run out through yellow
// and all-red.
//
// Ports:
//   clk      - rising-edge clock
//   rst_a    - synchronous active-high reset
//   sense    - per-approach vehicle-present flags
//   emg_req  - emergency preemption request (level)
//   emg_dir  - approach to receive the emergency green
//   lights   - 3-bit lamp code per approach (000 red, 001 green, 010 yellow)
//   cur_dir  - approach that owns, or last owned, the green
//   phase    - 00 ALL_RED, 01 GREEN, 10 YELLOW, 11 EMERG
module traffic_control_n #(
    parameter int unsigned NUM_DIR    = 4,
    parameter int unsigned DIR_W      = 2,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned GREEN_CYC  = 8,
    parameter int unsigned YELLOW_CYC = 4,
    parameter int unsigned ALLRED_CYC = 2,
    parameter int unsigned SKIP_EMPTY = 1
) (
    input  logic                   clk,
    input  logic                   rst_a,
    input  logic [NUM_DIR-1:0]     sense,
    input  logic                   emg_req,
    input  logic [DIR_W-1:0]       emg_dir,
    output logic [3*NUM_DIR-1:0]   lights,
    output logic [DIR_W-1:0]       cur_dir,
    output logic [1:0]             phase
);

    typedef enum logic [1:0] {
        PhAllRed = 2'b00,
        PhGreen  = 2'b01,
        PhYellow = 2'b10,
        PhEmerg  = 2'b11
    } phase_e;

    localparam logic [CNT_W-1:0] GreenLast  = CNT_W'(GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] YellowLast = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] AllRedLast = CNT_W'(ALLRED_CYC - 1);
    localparam logic [DIR_W-1:0] LastDir    = DIR_W'(NUM_DIR - 1);

    phase_e             phase_q, phase_d;
    logic [DIR_W-1:0]   cur_dir_q, cur_dir_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               emg_valid;
    logic [DIR_W-1:0]   next_rr;
    logic               scan_found;
    logic [DIR_W-1:0]   scan_dir;
    int unsigned        scan_idx;
    logic [NUM_DIR-1:0] sense_sh;

    // An out-of-range emergency direction counts as no request at all.
    assign emg_valid = emg_req && (32'(emg_dir) < NUM_DIR);
    assign next_rr   = (cur_dir_q == LastDir) ? '0 : cur_dir_q + 1'b1;

    // Round-robin search starting just after cur_dir and ending on cur_dir.
    always_comb begin
        scan_found = 1'b0;
        scan_dir   = cur_dir_q;
        scan_idx   = 0;
        sense_sh   = '0;
        for (int unsigned i = 1; i <= NUM_DIR; i++) begin
            scan_idx = (32'(cur_dir_q) + i) % NUM_DIR;
            sense_sh = sense >> scan_idx;
            if (!scan_found && sense_sh[0]) begin
                scan_found = 1'b1;
                scan_dir   = DIR_W'(scan_idx);
            end
        end
    end

    always_comb begin
        phase_d   = phase_q;
        cur_dir_d = cur_dir_q;
        count_d   = count_q;
        unique case (phase_q)
            PhAllRed: begin
                if (count_q != AllRedLast) begin
                    count_d = count_q + 1'b1;
                end else if (emg_valid) begin
                    phase_d   = PhEmerg;
                    cur_dir_d = emg_dir;
                    count_d   = '0;
                end else if (SKIP_EMPTY == 0) begin
                    phase_d   = PhGreen;
                    cur_dir_d = next_rr;
                    count_d   = '0;
                end else if (scan_found) begin
                    phase_d   = PhGreen;
                    cur_dir_d = scan_dir;
                    count_d   = '0;
                end
                // Nobody waiting: hold at expiry and re-evaluate every cycle.
            end
            PhGreen: begin
                if (emg_valid) begin
                    phase_d = (emg_dir == cur_dir_q) ? PhEmerg : PhYellow;
                    count_d = '0;
                end else if (count_q == GreenLast) begin
                    phase_d = PhYellow;
                    count_d = '0;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            PhYellow: begin
                if (count_q == YellowLast) begin
                    phase_d = PhAllRed;
                    count_d = '0;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            PhEmerg: begin
                // A retargeted request must clear through yellow like a release.
                if (!(emg_valid && emg_dir == cur_dir_q)) begin
                    phase_d = PhYellow;
                    count_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_a) begin
            phase_q   <= PhAllRed;
            cur_dir_q <= LastDir;
            count_q   <= '0;
        end else begin
            phase_q   <= phase_d;
            cur_dir_q <= cur_dir_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        lights = '0;
        for (int unsigned k = 0; k < NUM_DIR; k++) begin
            if (32'(cur_dir_q) == k) begin
                unique case (phase_q)
                    PhGreen, PhEmerg: lights[3*k +: 3] = 3'b001;
                    PhYellow:         lights[3*k +: 3] = 3'b010;
                    PhAllRed:         lights[3*k +: 3] = 3'b000;
                endcase
            end
        end
    end

    assign cur_dir = cur_dir_q;
    assign phase   = phase_q;

endmodule

// File: tb/tb_traffic_control_n.sv
// Bench for traffic_control_n: a default 4-way instance (skip enabled) and a
// 3-way instance with 1-cycle phases and plain rotation, both driven from the
// same stimulus and compared every cycle against a behavioural model.
module tb_traffic_control_n;

    logic        clk;
    logic        rst_a;
    logic [3:0]  sense;
    logic        emg_req;
    logic [1:0]  emg_dir;
    logic [11:0] lights4;
    logic [1:0]  cur_dir4, phase4;
    logic [8:0]  lights3;
    logic [1:0]  cur_dir3, phase3;

    traffic_control_n u_dut4 (
        .clk     (clk),
        .rst_a   (rst_a),
        .sense   (sense),
        .emg_req (emg_req),
        .emg_dir (emg_dir),
        .lights  (lights4),
        .cur_dir (cur_dir4),
        .phase   (phase4)
    );

    traffic_control_n #(
        .NUM_DIR    (3),
        .DIR_W      (2),
        .CNT_W      (8),
        .GREEN_CYC  (1),
        .YELLOW_CYC (1),
        .ALLRED_CYC (1),
        .SKIP_EMPTY (0)
    ) u_dut3 (
        .clk     (clk),
        .rst_a   (rst_a),
        .sense   (sense[2:0]),
        .emg_req (emg_req),
        .emg_dir (emg_dir),
        .lights  (lights3),
        .cur_dir (cur_dir3),
        .phase   (phase3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model state: phase code, owning approach, cycles left in this phase.
    typedef struct packed {
        int ph;
        int dir;
        int left;
    } mdl_t;

    function automatic mdl_t mdl_step(mdl_t s, int n, int g, int y, int ar, bit skip, bit rst,
                                      logic [15:0] sns, bit er, int ed);
        mdl_t r;
        bit   ev;
        int   d;
        r  = s;
        ev = er && (ed < n);
        if (rst) begin
            r.ph = 0; r.dir = n - 1; r.left = ar;
            return r;
        end
        case (s.ph)
            0: begin
                if (s.left > 1) r.left = s.left - 1;
                else if (ev) begin r.ph = 3; r.dir = ed; r.left = 0; end
                else if (!skip) begin r.ph = 1; r.dir = (s.dir + 1) % n; r.left = g; end
                else begin
                    for (int k = 1; k <= n; k++) begin
                        d = (s.dir + k) % n;
                        if (r.ph == 0 && sns[d]) begin r.ph = 1; r.dir = d; r.left = g; end
                    end
                end
            end
            1: begin
                if (ev) begin r.ph = (ed == s.dir) ? 3 : 2; r.left = y; end
                else if (s.left == 1) begin r.ph = 2; r.left = y; end
                else r.left = s.left - 1;
            end
            2: begin
                if (s.left == 1) begin r.ph = 0; r.left = ar; end
                else r.left = s.left - 1;
            end
            default: begin
                if (!(ev && ed == s.dir)) begin r.ph = 2; r.left = y; end
            end
        endcase
        return r;
    endfunction

    function automatic logic [47:0] exp_lights(int ph, int dir, int n);
        logic [47:0] l;
        l = '0;
        for (int k = 0; k < n; k++) begin
            if (k == dir && (ph == 1 || ph == 3)) l[3*k +: 3] = 3'b001;
            if (k == dir && ph == 2)              l[3*k +: 3] = 3'b010;
        end
        return l;
    endfunction

    function automatic int lit_count(logic [47:0] l, int n);
        int c;
        c = 0;
        for (int k = 0; k < n; k++) if (l[3*k +: 3] != 3'b000) c++;
        return c;
    endfunction

    mdl_t m4 = '0;
    mdl_t m3 = '0;
    int   tcount = 0;

    task automatic tick();
        m4 = mdl_step(m4, 4, 8, 4, 2, 1'b1, rst_a, 16'(sense), emg_req, int'(emg_dir));
        m3 = mdl_step(m3, 3, 1, 1, 1, 1'b0, rst_a, 16'(sense[2:0]), emg_req, int'(emg_dir));
        @(negedge clk);
        tcount++;
        check("phase4", 64'(phase4), 64'(m4.ph));
        check("dir4", 64'(cur_dir4), 64'(m4.dir));
        check("lights4", 64'(lights4), 64'(exp_lights(m4.ph, m4.dir, 4)));
        check("one_lamp4", 64'(lit_count(48'(lights4), 4) <= 1), 64'd1);
        check("phase3", 64'(phase3), 64'(m3.ph));
        check("dir3", 64'(cur_dir3), 64'(m3.dir));
        check("lights3", 64'(lights3), 64'(exp_lights(m3.ph, m3.dir, 3)));
    endtask

    task automatic do_reset();
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        tcount = 0;
    endtask

    int exp_gc[5] = '{2, 16, 30, 44, 58};
    int exp_gd[5] = '{0, 1, 2, 3, 0};
    int gs_cyc[5];
    int gs_dir[5];
    int ng;
    bit prev_green;
    int alt_exp;

    initial begin
        rst_a   = 1'b1;
        sense   = 4'hf;
        emg_req = 1'b0;
        emg_dir = 2'd0;
        @(negedge clk);

        // Plain rotation: green start cycles and order.
        do_reset();
        check("rst_phase", 64'(phase4), 64'd0);
        check("rst_dir", 64'(cur_dir4), 64'd3);
        check("rst_lights", 64'(lights4), 64'd0);
        ng = 0;
        prev_green = 1'b0;
        for (int i = 0; i < 120; i++) begin
            tick();
            if (phase4 == 2'd1 && !prev_green && ng < 5) begin
                gs_cyc[ng] = tcount;
                gs_dir[ng] = int'(cur_dir4);
                ng++;
            end
            prev_green = (phase4 == 2'd1);
            if (tcount % 3 == 1) begin
                check("d3_green", 64'(phase3), 64'd1);
                check("d3_dir", 64'(cur_dir3), 64'(((tcount - 1) / 3) % 3));
            end
        end
        check("green_count", 64'(ng), 64'd5);
        for (int i = 0; i < 5; i++) begin
            check("green_start", 64'(gs_cyc[i]), 64'(exp_gc[i]));
            check("green_dir", 64'(gs_dir[i]), 64'(exp_gd[i]));
        end

        // Skipping: only approaches 1 and 3 request service.
        sense = 4'b1010;
        alt_exp = 1;
        prev_green = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (phase4 == 2'd1 && !prev_green) begin
                check("alt_dir", 64'(cur_dir4), 64'(alt_exp));
                alt_exp = (alt_exp == 1) ? 3 : 1;
            end
            prev_green = (phase4 == 2'd1);
        end
        sense = 4'b0000;
        repeat (30) tick();
        check("stall_phase", 64'(phase4), 64'd0);
        check("stall_lights", 64'(lights4), 64'd0);
        sense = 4'b0001;
        tick();
        check("wake_phase", 64'(phase4), 64'd1);
        check("wake_dir", 64'(cur_dir4), 64'd0);

        // Preemption from green on approach 0 towards approach 2.
        sense = 4'hf;
        do_reset();
        for (int i = 0; i < 10 && phase4 != 2'd1; i++) tick();
        check("pre_green", 64'(phase4), 64'd1);
        repeat (2) tick();
        emg_req = 1'b1;
        emg_dir = 2'd2;
        tick();
        check("pre_yellow", 64'(phase4), 64'd2);
        check("pre_ydir", 64'(cur_dir4), 64'd0);
        repeat (5) tick();
        check("pre_allred", 64'(phase4), 64'd0);
        tick();
        check("emerg_phase", 64'(phase4), 64'd3);
        check("emerg_lights", 64'(lights4), 64'h040);
        emg_req = 1'b0;
        tick();
        check("rel_yellow", 64'(phase4), 64'd2);
        check("rel_dir", 64'(cur_dir4), 64'd2);
        repeat (6) tick();
        check("resume_phase", 64'(phase4), 64'd1);
        check("resume_dir", 64'(cur_dir4), 64'd3);

        // Same-direction request: green continues as emergency.
        emg_req = 1'b1;
        emg_dir = 2'd3;
        tick();
        check("same_emerg", 64'(phase4), 64'd3);
        check("same_lights", 64'(lights4), 64'h200);
        emg_req = 1'b0;
        tick();
        check("same_rel", 64'(phase4), 64'd2);

        // Reset mid-yellow and mid-emergency.
        tick();
        do_reset();
        check("ry_phase", 64'(phase4), 64'd0);
        check("ry_lights", 64'(lights4), 64'd0);
        check("ry_dir", 64'(cur_dir4), 64'd3);
        emg_req = 1'b1;
        emg_dir = 2'd1;
        for (int i = 0; i < 40 && phase4 != 2'd3; i++) tick();
        check("reach_emerg", 64'(phase4), 64'd3);
        emg_req = 1'b0;
        do_reset();
        check("re_phase", 64'(phase4), 64'd0);
        check("re_lights", 64'(lights4), 64'd0);
        check("re_dir", 64'(cur_dir4), 64'd3);
        repeat (2) tick();
        check("re_green", 64'(phase4), 64'd1);
        check("re_gdir", 64'(cur_dir4), 64'd0);

        // Random traffic, emergencies (including out-of-range for the 3-way) and resets.
        for (int i = 0; i < 2500; i++) begin
            rst_a = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 19) == 0) emg_req = ~emg_req;
            if ($urandom_range(0, 9) == 0)  emg_dir = 2'($urandom);
            if ($urandom_range(0, 7) == 0)  sense = 4'($urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
